// File: rtl/mod_exp_seq.sv
// Square-and-multiply sequencer driving a modular multiplier over a start/end handshake.
// Optional build macro MOD_EXP_SEQ_CONST_TIME_EN: always issue the multiply step (constant request count).
module mod_exp_seq (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    input  logic [7:0]  len,
    input  logic [5:0]  exp_len,
    input  logic [31:0] base,
    input  logic [31:0] exponent,
    input  logic [31:0] modulus,
    output logic        mul_start,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    output logic [31:0] mul_mod,
    output logic [7:0]  mul_len,
    input  logic        mul_end,
    input  logic [31:0] mul_out,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_SQ_REQ   = 3'd1;
    localparam logic [2:0] S_SQ_WAIT  = 3'd2;
    localparam logic [2:0] S_MUL_REQ  = 3'd3;
    localparam logic [2:0] S_MUL_WAIT = 3'd4;
    localparam logic [2:0] S_DONE     = 3'd5;

    logic [2:0]  state_q, state_d;
    logic [31:0] acc_q, acc_d;
    logic [31:0] base_q, base_d;
    logic [31:0] exp_q, exp_d;
    logic [31:0] mod_q, mod_d;
    logic [7:0]  len_q, len_d;
    logic [4:0]  idx_q, idx_d;
    logic [31:0] result_q, result_d;

    logic [5:0]  exp_len_c;
    logic        bit_set;
    logic        last_bit;
    logic [31:0] mul_acc;

    assign exp_len_c = (exp_len > 6'd32) ? 6'd32 : exp_len;
    assign bit_set   = exp_q[idx_q];
    assign last_bit  = (idx_q == 5'd0);

`ifdef MOD_EXP_SEQ_CONST_TIME_EN
    // The product of a dummy multiply is dropped so timing does not depend on the bit.
    assign mul_acc = bit_set ? mul_out : acc_q;
`else
    assign mul_acc = mul_out;
`endif

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        base_d   = base_q;
        exp_d    = exp_q;
        mod_d    = mod_q;
        len_d    = len_q;
        idx_d    = idx_q;
        result_d = result_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    base_d = base;
                    exp_d  = exponent;
                    mod_d  = modulus;
                    len_d  = len;
                    acc_d  = 32'd1;
                    // exp_len=32 wraps the low five bits to 0, so minus one lands on 31.
                    idx_d  = exp_len_c[4:0] - 5'd1;
                    if (exp_len_c == 6'd0) begin
                        result_d = 32'd1;
                        state_d  = S_DONE;
                    end else begin
                        state_d  = S_SQ_REQ;
                    end
                end
            end
            S_SQ_REQ:  state_d = S_SQ_WAIT;
            S_SQ_WAIT: begin
                if (mul_end) begin
                    acc_d = mul_out;
`ifdef MOD_EXP_SEQ_CONST_TIME_EN
                    state_d = S_MUL_REQ;
`else
                    if (bit_set) begin
                        state_d = S_MUL_REQ;
                    end else if (last_bit) begin
                        result_d = mul_out;
                        state_d  = S_DONE;
                    end else begin
                        idx_d   = idx_q - 5'd1;
                        state_d = S_SQ_REQ;
                    end
`endif
                end
            end
            S_MUL_REQ: state_d = S_MUL_WAIT;
            S_MUL_WAIT: begin
                if (mul_end) begin
                    acc_d = mul_acc;
                    if (last_bit) begin
                        result_d = mul_acc;
                        state_d  = S_DONE;
                    end else begin
                        idx_d   = idx_q - 5'd1;
                        state_d = S_SQ_REQ;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= S_IDLE;
            acc_q    <= 32'd0;
            base_q   <= 32'd0;
            exp_q    <= 32'd0;
            mod_q    <= 32'd0;
            len_q    <= 8'd0;
            idx_q    <= 5'd0;
            result_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            base_q   <= base_d;
            exp_q    <= exp_d;
            mod_q    <= mod_d;
            len_q    <= len_d;
            idx_q    <= idx_d;
            result_q <= result_d;
        end
    end

    // acc only moves on mul_end, so operands stay stable from request through completion.
    assign mul_start = (state_q == S_SQ_REQ) || (state_q == S_MUL_REQ);
    assign mul_a     = acc_q;
    assign mul_b     = ((state_q == S_MUL_REQ) || (state_q == S_MUL_WAIT)) ? base_q : acc_q;
    assign mul_mod   = mod_q;
    assign mul_len   = len_q;
    assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done      = (state_q == S_DONE);
    assign result    = result_q;

endmodule
